// File: rtl/conv3x3_stream_if.sv
// Pixel stream bundle for conv3x3_stream: s_* carries raster input, m_* carries filtered output.
// The slave modport is the engine's view; master is the source/sink side.
interface conv3x3_stream_if #(
    parameter int unsigned PIXEL_WIDTH = 8
);
    logic                   s_valid;
    logic                   s_ready;
    logic [PIXEL_WIDTH-1:0] s_data;
    logic                   s_sof;
    logic                   m_valid;
    logic                   m_ready;
    logic [PIXEL_WIDTH-1:0] m_data;
    logic                   m_sof;
    logic                   m_eol;
    logic                   m_eof;

    modport slave (
        input  s_valid, s_data, s_sof, m_ready,
        output s_ready, m_valid, m_data, m_sof, m_eol, m_eof
    );

    modport master (
        output s_valid, s_data, s_sof, m_ready,
        input  s_ready, m_valid, m_data, m_sof, m_eol, m_eof
    );
endinterface

// File: rtl/conv3x3_stream.sv
// Streaming 3x3 convolution (pass/sharpen/gaussian/edge) with two internal line buffers.
// Optional CONV_EDGE_ABS_EN: edge mode outputs |edge| instead of clamping negatives to 0.
module conv3x3_stream #(
    parameter int unsigned PIXEL_WIDTH = 8,
    parameter int unsigned IMG_WIDTH   = 640,
    parameter int unsigned IMG_HEIGHT  = 480,
    parameter int unsigned ACCW        = PIXEL_WIDTH + 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        mode,
    conv3x3_stream_if.slave   bus
);
    localparam int unsigned CW = $clog2(IMG_WIDTH);
    localparam int unsigned RW = $clog2(IMG_HEIGHT);
    localparam logic signed [ACCW-1:0] MAX_ACC   =
        $signed({{(ACCW-PIXEL_WIDTH){1'b0}}, {PIXEL_WIDTH{1'b1}}});
    localparam logic signed [ACCW-1:0] GAUSS_RND = ACCW'(8);

    typedef enum logic [1:0] {
        MODE_PASS    = 2'd0,
        MODE_SHARPEN = 2'd1,
        MODE_GAUSS   = 2'd2,
        MODE_EDGE    = 2'd3
    } mode_e;

    mode_e                  mode_q;
    logic [CW-1:0]          col_q, col_eff;
    logic [RW-1:0]          row_q, row_eff;
    logic                   accept_c;
    logic                   produce_c;
    logic [PIXEL_WIDTH-1:0] top_c, mid_c;
    logic [PIXEL_WIDTH-1:0] t0, t1, m0, m1, b0, b1;
    logic [PIXEL_WIDTH-1:0] lb0 [IMG_WIDTH];
    logic [PIXEL_WIDTH-1:0] lb1 [IMG_WIDTH];

    logic signed [ACCW-1:0] p_nw, p_n, p_ne, p_w, p_c, p_e, p_sw, p_s, p_se;
    logic signed [ACCW-1:0] edge_c, acc_c;
    logic [PIXEL_WIDTH-1:0] pix_c;

    function automatic logic signed [ACCW-1:0] zx(input logic [PIXEL_WIDTH-1:0] p);
        return $signed({{(ACCW-PIXEL_WIDTH){1'b0}}, p});
    endfunction

    assign bus.s_ready = !bus.m_valid || bus.m_ready;
    assign accept_c    = bus.s_valid && bus.s_ready;

    // s_sof overrides the counters so a frame start always lands on (0,0)
    assign col_eff   = bus.s_sof ? '0 : col_q;
    assign row_eff   = bus.s_sof ? '0 : row_q;
    assign top_c     = lb1[col_eff];
    assign mid_c     = lb0[col_eff];
    assign produce_c = (row_eff >= RW'(2)) && (col_eff >= CW'(2));

    // Raster position, latched mode and window columns
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q  <= '0;
            row_q  <= '0;
            mode_q <= MODE_PASS;
            t0 <= '0; t1 <= '0;
            m0 <= '0; m1 <= '0;
            b0 <= '0; b1 <= '0;
        end else if (accept_c) begin
            if (col_eff == CW'(IMG_WIDTH - 1)) begin
                col_q <= '0;
                row_q <= (row_eff == RW'(IMG_HEIGHT - 1)) ? '0 : row_eff + RW'(1);
            end else begin
                col_q <= col_eff + CW'(1);
                row_q <= row_eff;
            end
            if ((col_eff == '0) && (row_eff == '0)) begin
                mode_q <= mode_e'(mode);
            end
            t0 <= t1; t1 <= top_c;
            m0 <= m1; m1 <= mid_c;
            b0 <= b1; b1 <= bus.s_data;
        end
    end

    // Line storage is never reset; rows 0 and 1 refill it before any output uses it
    always_ff @(posedge clk) begin
        if (accept_c) begin
            lb1[col_eff] <= mid_c;
            lb0[col_eff] <= bus.s_data;
        end
    end

    // Kernel evaluation on the window whose right column is arriving this cycle
    always_comb begin
        p_nw = zx(t0); p_n = zx(t1); p_ne = zx(top_c);
        p_w  = zx(m0); p_c = zx(m1); p_e  = zx(mid_c);
        p_sw = zx(b0); p_s = zx(b1); p_se = zx(bus.s_data);
        edge_c = (p_c <<< 3) - (p_nw + p_n + p_ne + p_w + p_e + p_sw + p_s + p_se);
        acc_c  = p_c;
        case (mode_q)
            MODE_PASS:    acc_c = p_c;
            MODE_SHARPEN: acc_c = (p_c <<< 2) + p_c - p_n - p_s - p_e - p_w;
            MODE_GAUSS:   acc_c = (p_nw + p_ne + p_sw + p_se
                                   + ((p_n + p_w + p_e + p_s) <<< 1)
                                   + (p_c <<< 2) + GAUSS_RND) >>> 4;
`ifdef CONV_EDGE_ABS_EN
            MODE_EDGE:    acc_c = edge_c[ACCW-1] ? -edge_c : edge_c;
`else
            MODE_EDGE:    acc_c = edge_c;
`endif
            default:      acc_c = p_c;
        endcase

        if (acc_c[ACCW-1]) begin
            pix_c = '0;
        end else if (acc_c > MAX_ACC) begin
            pix_c = '1;
        end else begin
            pix_c = acc_c[PIXEL_WIDTH-1:0];
        end
    end

    // One-deep output register; a fresh result wins over a simultaneous drain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.m_valid <= 1'b0;
            bus.m_data  <= '0;
            bus.m_sof   <= 1'b0;
            bus.m_eol   <= 1'b0;
            bus.m_eof   <= 1'b0;
        end else if (accept_c && produce_c) begin
            bus.m_valid <= 1'b1;
            bus.m_data  <= pix_c;
            bus.m_sof   <= (row_eff == RW'(2)) && (col_eff == CW'(2));
            bus.m_eol   <= (col_eff == CW'(IMG_WIDTH - 1));
            bus.m_eof   <= (row_eff == RW'(IMG_HEIGHT - 1)) && (col_eff == CW'(IMG_WIDTH - 1));
        end else if (bus.m_ready) begin
            bus.m_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_conv3x3_stream.sv
// Directed bench for conv3x3_stream on a 4x4 image: kernel/pattern vector table plus
// sequences for mode hold, random backpressure, mid-frame reset and s_sof resync.
`timescale 1ns/1ps
module tb_conv3x3_stream;
    localparam int unsigned PW = 8;
    localparam int W    = 4;
    localparam int H    = 4;
    localparam int NPIX = W * H;
`ifdef CONV_EDGE_ABS_EN
    localparam int NEG_EDGE = 255;
`else
    localparam int NEG_EDGE = 0;
`endif

    typedef struct packed {
        logic [PW-1:0] d;
        logic          sof;
        logic          eol;
        logic          eof;
    } out_t;

    typedef struct {
        logic [1:0] mode;
        int         pat;
        int         e [4];
        string      name;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] mode;
    int         n_vec = 0;
    int         n_bad = 0;
    int         ready_mode = 0;
    out_t       got [$];
    out_t       exp_q [$];
    logic [PW-1:0] img [NPIX];
    vec_t       tbl [12];

    conv3x3_stream_if #(.PIXEL_WIDTH(PW)) bus ();

    conv3x3_stream #(
        .PIXEL_WIDTH(PW), .IMG_WIDTH(W), .IMG_HEIGHT(H), .ACCW(PW + 6)
    ) dut (
        .clk(clk), .rst(rst), .mode(mode), .bus(bus)
    );

    always #5 clk = ~clk;

    // Sink: 0 = always ready, 1 = random ~50%, 2 = held off
    initial begin
        bus.m_ready = 1'b1;
        forever begin
            @(posedge clk); #2;
            case (ready_mode)
                1:       bus.m_ready = 1'($urandom_range(0, 1));
                2:       bus.m_ready = 1'b0;
                default: bus.m_ready = 1'b1;
            endcase
        end
    end

    // Output monitor: records handshakes and checks hold-stability under stall
    out_t cur, held;
    logic stall_prev = 1'b0;
    always @(negedge clk) begin
        cur = out_t'({bus.m_data, bus.m_sof, bus.m_eol, bus.m_eof});
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                n_vec++;
                if (!bus.m_valid || cur !== held) begin
                    n_bad++;
                    $display("FAIL stall_hold: got valid=%b d=%0d flags=%b%b%b, expected valid=1 d=%0d flags=%b%b%b",
                             bus.m_valid, cur.d, cur.sof, cur.eol, cur.eof, held.d, held.sof, held.eol, held.eof);
                end
            end
            if (bus.m_valid && bus.m_ready) got.push_back(cur);
            stall_prev = bus.m_valid && !bus.m_ready;
            held = cur;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

    function automatic out_t mk(input int d, input int k);
        out_t o;
        o.d   = PW'(d);
        o.sof = (k == 0);
        o.eol = (k % 2 == 1);
        o.eof = (k == 3);
        return o;
    endfunction

    // Direct 2-D convolution reference for interior centre (r,c) of img
    function automatic int ref_pix(input int r, input int c, input logic [1:0] m);
        int k [9];
        int acc;
        acc = 0;
        case (m)
            2'd0:    k = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
            2'd1:    k = '{0, -1, 0, -1, 5, -1, 0, -1, 0};
            2'd2:    k = '{1, 2, 1, 2, 4, 2, 1, 2, 1};
            default: k = '{-1, -1, -1, -1, 8, -1, -1, -1, -1};
        endcase
        for (int dr = -1; dr <= 1; dr++)
            for (int dc = -1; dc <= 1; dc++)
                acc += k[(dr + 1) * 3 + dc + 1] * int'(img[(r + dr) * W + c + dc]);
        if (m == 2'd2) acc = (acc + 8) / 16;
        if (m == 2'd3 && acc < 0) acc = (NEG_EDGE != 0) ? -acc : 0;
        if (acc < 0) acc = 0;
        if (acc > 255) acc = 255;
        return acc;
    endfunction

    task automatic push_expected(input logic [1:0] m);
        int k;
        k = 0;
        for (int r = 1; r < H - 1; r++)
            for (int c = 1; c < W - 1; c++) begin
                exp_q.push_back(mk(ref_pix(r, c, m), k));
                k++;
            end
    endtask

    task automatic fill_img(input int pat);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                case (pat)
                    0:       img[r * W + c] = 8'd100;
                    1:       img[r * W + c] = PW'(16 * c);
                    2:       img[r * W + c] = (r == 1 && c == 1) ? 8'd255 : 8'd0;
                    default: img[r * W + c] = PW'($urandom_range(0, 255));
                endcase
    endtask

    task automatic push_pix(input logic [PW-1:0] d, input logic sof);
        bit acc;
        int t;
        acc = 0;
        t   = 0;
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        bus.s_sof   = sof;
        while (!acc && t < 300) begin
            @(negedge clk);
            acc = bus.s_ready;
            @(posedge clk); #1;
            t++;
        end
        bus.s_valid = 1'b0;
        bus.s_sof   = 1'b0;
        if (!acc) begin
            n_vec++;
            n_bad++;
            $display("FAIL push_timeout: s_ready=0 for %0d cycles, expected 1", t);
        end
    endtask

    task automatic send_frame(input logic [1:0] m_first, input logic [1:0] m_rest,
                              input int npix, input bit sof, input bit gaps);
        for (int i = 0; i < npix; i++) begin
            mode = (i == 0) ? m_first : m_rest;
            if (gaps && $urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
            push_pix(img[i], sof && (i == 0));
        end
    endtask

    task automatic check_queue(input string name, input int n);
        int   t;
        out_t g, e;
        t = 0;
        while (got.size() < n && t < 2000) begin
            @(posedge clk);
            t++;
        end
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if (got.size() != n) begin
            n_bad++;
            $display("FAIL %s_count: got %0d outputs, expected %0d", name, got.size(), n);
        end
        for (int i = 0; i < n && got.size() > 0 && exp_q.size() > 0; i++) begin
            g = got.pop_front();
            e = exp_q.pop_front();
            n_vec++;
            if (g !== e) begin
                n_bad++;
                $display("FAIL %s[%0d]: got d=%0d sof=%b eol=%b eof=%b, expected d=%0d sof=%b eol=%b eof=%b",
                         name, i, g.d, g.sof, g.eol, g.eof, e.d, e.sof, e.eol, e.eof);
            end
        end
        got.delete();
        exp_q.delete();
    endtask

    task automatic check_idle(input string name);
        n_vec++;
        if (bus.m_valid !== 1'b0 || bus.s_ready !== 1'b1 || bus.m_data !== '0 ||
            {bus.m_sof, bus.m_eol, bus.m_eof} !== 3'b000) begin
            n_bad++;
            $display("FAIL %s: got m_valid=%b s_ready=%b m_data=%0d flags=%b%b%b, expected 0 1 0 000",
                     name, bus.m_valid, bus.s_ready, bus.m_data, bus.m_sof, bus.m_eol, bus.m_eof);
        end
    endtask

    initial begin
        tbl[0]  = '{2'd0, 0, '{100, 100, 100, 100}, "const_pass"};
        tbl[1]  = '{2'd1, 0, '{100, 100, 100, 100}, "const_sharpen"};
        tbl[2]  = '{2'd2, 0, '{100, 100, 100, 100}, "const_gauss"};
        tbl[3]  = '{2'd3, 0, '{0, 0, 0, 0},         "const_edge"};
        tbl[4]  = '{2'd0, 1, '{16, 32, 16, 32},     "ramp_pass"};
        tbl[5]  = '{2'd1, 1, '{16, 32, 16, 32},     "ramp_sharpen"};
        tbl[6]  = '{2'd2, 1, '{16, 32, 16, 32},     "ramp_gauss"};
        tbl[7]  = '{2'd3, 1, '{0, 0, 0, 0},         "ramp_edge"};
        tbl[8]  = '{2'd0, 2, '{255, 0, 0, 0},       "impulse_pass"};
        tbl[9]  = '{2'd1, 2, '{255, 0, 0, 0},       "impulse_sharpen"};
        tbl[10] = '{2'd2, 2, '{64, 32, 32, 16},     "impulse_gauss"};
        tbl[11] = '{2'd3, 2, '{255, NEG_EDGE, NEG_EDGE, NEG_EDGE}, "impulse_edge"};

        rst = 1'b1;
        mode = 2'd0;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.s_sof   = 1'b0;
        #3 check_idle("reset_async");
        repeat (3) @(posedge clk);
        #1 check_idle("reset_hold");
        rst = 1'b0;
        @(posedge clk); #1;
        check_idle("after_reset");

        for (int i = 0; i < 12; i++) begin
            fill_img(tbl[i].pat);
            for (int k = 0; k < 4; k++) exp_q.push_back(mk(tbl[i].e[k], k));
            send_frame(tbl[i].mode, tbl[i].mode, NPIX, 1'b1, 1'b0);
            check_queue(tbl[i].name, 4);
        end

        // Mode changes after (0,0) must not affect the frame in flight
        fill_img(0);
        for (int k = 0; k < 4; k++) exp_q.push_back(mk(100, k));
        send_frame(2'd2, 2'd3, NPIX, 1'b1, 1'b0);
        check_queue("mode_hold_gauss", 4);
        for (int k = 0; k < 4; k++) exp_q.push_back(mk(0, k));
        send_frame(2'd3, 2'd0, NPIX, 1'b1, 1'b0);
        check_queue("mode_hold_edge", 4);

        // Ten back-to-back random frames under random backpressure; odd frames start by wrap
        ready_mode = 1;
        for (int f = 0; f < 10; f++) begin
            logic [1:0] m;
            m = 2'($urandom_range(0, 3));
            fill_img(3);
            push_expected(m);
            send_frame(m, m, NPIX, (f % 2) == 0, 1'b1);
        end
        check_queue("random", 40);
        ready_mode = 0;

        // Reset after 7 accepts, then a clean frame
        fill_img(0);
        send_frame(2'd1, 2'd1, 7, 1'b1, 1'b0);
        rst = 1'b1;
        #1 check_idle("reset_midframe");
        @(posedge clk); #1;
        rst = 1'b0;
        got.delete();
        exp_q.delete();
        fill_img(2);
        push_expected(2'd2);
        send_frame(2'd2, 2'd2, NPIX, 1'b1, 1'b0);
        check_queue("post_reset", 4);

        // s_sof after 6 pixels, then a frame left with one stalled output, then resync
        fill_img(0);
        send_frame(2'd0, 2'd0, 6, 1'b1, 1'b0);
        ready_mode = 2;
        fill_img(1);
        send_frame(2'd0, 2'd0, 11, 1'b1, 1'b0);
        exp_q.push_back(mk(16, 0));
        fill_img(2);
        push_expected(2'd2);
        fork
            send_frame(2'd2, 2'd2, NPIX, 1'b1, 1'b0);
            begin
                repeat (6) @(posedge clk);
                #1 ready_mode = 0;
            end
        join
        check_queue("resync", 5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
